pat_gen: RTL and testbench



---
 rtl/pat_gen.sv | 99 +++++++++
 tb/tb_pat_gen.sv | 110 +++++++++++
 2 files changed

// File: rtl/pat_gen.sv
// pat_gen: raster timing + test-pattern generator; in clk, rst_n, dis_sn[6:0], flag_black_on; out hs, vs, de, frame_start, data_r/g/b[7:0] (all registered, 1-clock latency)
module pat_gen #(
    parameter int H_SYNC = 2,
    parameter int H_BP   = 2,
    parameter int H_ACT  = 16,
    parameter int H_FP   = 2,
    parameter int V_SYNC = 1,
    parameter int V_BP   = 1,
    parameter int V_ACT  = 8,
    parameter int V_FP   = 1,
    parameter int CHK_SH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] dis_sn,
    input  logic       flag_black_on,
    output logic       hs,
    output logic       vs,
    output logic       de,
    output logic [7:0] data_r,
    output logic [7:0] data_g,
    output logic [7:0] data_b,
    output logic       frame_start
);
    localparam logic [15:0] H_TOTAL = 16'(H_SYNC + H_BP + H_ACT + H_FP);
    localparam logic [15:0] V_TOTAL = 16'(V_SYNC + V_BP + V_ACT + V_FP);
    localparam logic [15:0] HA0     = 16'(H_SYNC + H_BP);
    localparam logic [15:0] VA0     = 16'(V_SYNC + V_BP);
    localparam logic [15:0] HA1     = 16'(H_SYNC + H_BP + H_ACT);
    localparam logic [15:0] VA1     = 16'(V_SYNC + V_BP + V_ACT);
    localparam logic [15:0] HS_W    = 16'(H_SYNC);
    localparam logic [15:0] VS_W    = 16'(V_SYNC);
    localparam logic [15:0] BAR_W   = 16'(H_ACT / 8);
    logic [15:0]     h_cnt, v_cnt, h_nxt, v_nxt, bar_pos;
    logic [7:0]      x;
    logic [CHK_SH:0] y;
    logic [2:0]      bar_idx;
    logic [6:0]      pat_sn;
    logic            h_end, v_end, act;
    logic [23:0]     rgb;
    always_comb begin
        h_end = h_cnt == H_TOTAL - 16'd1;
        v_end = v_cnt == V_TOTAL - 16'd1;
        h_nxt = h_end ? 16'd0 : h_cnt + 16'd1;
        v_nxt = !h_end ? v_cnt : v_end ? 16'd0 : v_cnt + 16'd1;
        x     = h_cnt[7:0] - HA0[7:0];
        y     = v_cnt[CHK_SH:0] - VA0[CHK_SH:0];
        act   = h_cnt >= HA0 && h_cnt < HA1 && v_cnt >= VA0 && v_cnt < VA1;
        rgb   = 24'h000000;
        case (pat_sn)
            7'd1:    rgb = 24'hFFFFFF;
            7'd2:    rgb = 24'hFF0000;
            7'd3:    rgb = 24'h00FF00;
            7'd4:    rgb = 24'h0000FF;
            7'd5:    rgb = 24'h808080;
            7'd6:    rgb = {3{x}};
            7'd7:    rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            7'd8:    rgb = (x[CHK_SH] ^ y[CHK_SH]) ? 24'h000000 : 24'hFFFFFF;
            7'd9:    rgb = x[0] ? 24'h000000 : 24'hFFFFFF;
            7'd10:   rgb = y[0] ? 24'h000000 : 24'hFFFFFF;
            default: rgb = 24'h000000;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            pat_sn      <= '0;
            bar_idx     <= '0;
            bar_pos     <= '0;
            hs          <= 1'b0;
            vs          <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            data_r      <= '0;
            data_g      <= '0;
            data_b      <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (h_end && v_end)
                pat_sn <= dis_sn;
            // bar state is prepared one clock ahead so it is valid for the pixel at h_cnt
            if (h_nxt == HA0) begin
                bar_idx <= '0;
                bar_pos <= '0;
            end else if (bar_pos == BAR_W - 16'd1) begin
                bar_idx <= bar_idx + 3'd1;
                bar_pos <= '0;
            end else
                bar_pos <= bar_pos + 16'd1;
            hs          <= h_cnt < HS_W;
            vs          <= v_cnt < VS_W;
            de          <= act;
            frame_start <= h_cnt == 16'd0 && v_cnt == 16'd0;
            {data_r, data_g, data_b} <= (act && !flag_black_on) ? rgb : 24'h000000;
        end
    end
endmodule

// File: tb/tb_pat_gen.sv
// tb_pat_gen: randomized scoreboard bench for pat_gen against a frame-level reference model
module tb_pat_gen;
    localparam int HT = 22, VT = 11, FT = HT * VT;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    localparam logic [6:0] PATS [18] = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9,
                                         7'd10, 7'd11, 7'd12, 7'd127, 7'd0, 7'd7, 7'd8, 7'd6, 7'd9};
    logic       clk, rst_n, flag_black_on;
    logic [6:0] dis_sn;
    logic       hs, vs, de, frame_start;
    logic [7:0] data_r, data_g, data_b;
    logic [27:0] sb [$];
    int n_cmp = 0, n_bad = 0, k = 0, mpat = 0;
    pat_gen dut (
        .clk(clk), .rst_n(rst_n), .dis_sn(dis_sn), .flag_black_on(flag_black_on),
        .hs(hs), .vs(vs), .de(de), .data_r(data_r), .data_g(data_g), .data_b(data_b),
        .frame_start(frame_start)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    function automatic logic [23:0] colour(int p, int x, int y);
        case (p)
            1:       return 24'hFFFFFF;
            2:       return 24'hFF0000;
            3:       return 24'h00FF00;
            4:       return 24'h0000FF;
            5:       return 24'h808080;
            6:       return {3{8'(x)}};
            7:       return BARS[x / 2];
            8:       return ((x / 4 + y / 4) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
            9:       return (x % 2 == 0) ? 24'hFFFFFF : 24'h000000;
            10:      return (y % 2 == 0) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h000000;
        endcase
    endfunction
    function automatic logic [27:0] model(int cnt, int p, logic blk);
        int h, v;
        logic a;
        h = cnt % HT;
        v = (cnt / HT) % VT;
        a = h >= 4 && h < 20 && v >= 2 && v < 10;
        return {h < 2, v < 1, a, cnt % FT == 0, (a && !blk) ? colour(p, h - 4, v - 2) : 24'h000000};
    endfunction
    task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic cycle(input logic [6:0] d, input logic b);
        @(negedge clk);
        dis_sn = d;
        flag_black_on = b;
        sb.push_back(model(k, mpat, b));
        if (k % FT == FT - 1) mpat = int'(d);
        k++;
    endtask
    initial begin
        logic [27:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("scoreboard@%0t", $time),
                    {hs, vs, de, frame_start, data_r, data_g, data_b}, e);
            end
        end
    end
    initial begin
        logic [6:0] d;
        rst_n = 0;
        dis_sn = 7'd1;
        flag_black_on = 0;
        repeat (3) @(posedge clk);
        chk("reset_state", {hs, vs, de, frame_start, data_r, data_g, data_b}, 28'd0);
        #1 rst_n = 1;
        #1 chk("post_release", {hs, vs, de, frame_start, data_r, data_g, data_b}, 28'd0);
        d = 7'd1;
        for (int f = 0; f < 18; f++)
            for (int c = 0; c < FT; c++) begin
                if (c == 100) d = 7'($urandom_range(0, 127));
                if (c == FT - 1) d = PATS[f];
                cycle(d, $urandom_range(0, 9) == 0);
            end
        for (int c = 0; c < FT; c++) cycle(7'd1, 1'b0);
        repeat (HT * 4 + 11) cycle(7'd1, 1'b0);
        @(posedge clk);
        #3 chk("pre_reset_white", {19'd0, de, data_r}, {19'd0, 1'b1, 8'hFF});
        rst_n = 0;
        #1 chk("async_reset", {hs, vs, de, frame_start, data_r, data_g, data_b}, 28'd0);
        sb.delete();
        k = 0;
        mpat = 0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1;
        d = 7'd3;
        for (int c = 0; c < 3 * FT; c++) begin
            if (c % FT == FT - 1) d = 7'($urandom_range(0, 10));
            cycle(d, $urandom_range(0, 9) == 0);
        end
        @(posedge clk);
        #5 chk("queue_drained", 28'(sb.size()), 28'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
